// File: rtl/rtlmem_2rw2x_ctrl.sv
// Port-A request controller for the 2-port, 2-cycle-read shared RAM.
// Sequences the RAM clear, issues one command per cycle while credits remain,
// and returns read data in order through a credit-protected response FIFO.
// Optional even parity on the RAM word: define RTLMEM_2RW2X_CTRL_PARITY_EN.
//
// state    | meaning
// ST_CLR   | RAM clear in progress, clren high, no commands taken
// ST_RUN   | normal operation, commands accepted while credits remain
// ST_DRAIN | re-clear requested, waiting for the read pipeline to empty
module rtlmem_2rw2x_ctrl #(
  parameter int G_ADDR      = 10,
  parameter int G_WIDTH     = 16,
  parameter int G_RSP_DEPTH = 4
) (
  input  logic               clk_a,
  input  logic               rst_n,
  input  logic               init_req,
  output logic               init_done,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  input  logic               cmd_we,
  input  logic [G_ADDR-1:0]  cmd_ad,
  input  logic [G_WIDTH-1:0] cmd_di,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [G_WIDTH-1:0] rsp_do,
  output logic               rsp_err,
  output logic               clren,
  input  logic               clrrdy,
  output logic [G_ADDR-1:0]  memad_a,
  output logic               memwe_a,
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  output logic [G_WIDTH:0]   memdi_a,
`else
  output logic [G_WIDTH-1:0] memdi_a,
`endif
  output logic               memre_a,
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  input  logic [G_WIDTH:0]   memdo_a
`else
  input  logic [G_WIDTH-1:0] memdo_a
`endif
);

`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DW = G_WIDTH + P;
  localparam int CW = $clog2(G_RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(G_RSP_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {ST_CLR = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [CW-1:0]       fcnt_q, fcnt_d, wr_idx;
  logic [G_ADDR-1:0]   memad_q, memad_d;
  logic [DW-1:0]       memdi_q, memdi_d;
  logic                memwe_q, memwe_d, memre_q, memre_d;
  logic                re_d1_q, re_d1_d, re_d2_q, re_d2_d;
  logic [G_WIDTH-1:0]  fdat_q [G_RSP_DEPTH];
  logic [G_WIDTH-1:0]  fdat_d [G_RSP_DEPTH];
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  logic                ferr_q [G_RSP_DEPTH];
  logic                ferr_d [G_RSP_DEPTH];
`endif
  logic                accept, rd_acc, push, pop, pipe_empty;

  assign accept     = cmd_vld && cmd_rdy;
  assign rd_acc     = accept && !cmd_we;
  assign push       = re_d2_q;
  assign rsp_vld    = (fcnt_q != '0);
  assign pop        = rsp_vld && rsp_rdy;
  assign pipe_empty = !(memre_q || re_d1_q || re_d2_q);

  // Next state and state-derived outputs; a re-clear request closes cmd_rdy at once
  always_comb begin
    state_d   = state_q;
    cmd_rdy   = 1'b0;
    clren     = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_CLR: begin
        clren = 1'b1;
        if (clrrdy) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        if (init_req) state_d = ST_DRAIN;
        else          cmd_rdy = (out_cnt_q < DEPTH_C);
      end
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_CLR;
      end
      default: state_d = ST_CLR;
    endcase
  end

  // RAM command register and read-latency tracking pipeline
  always_comb begin
    memad_d = memad_q;
    memdi_d = memdi_q;
    memwe_d = accept && cmd_we;
    memre_d = rd_acc;
    re_d1_d = memre_q;
    re_d2_d = re_d1_q;
    if (accept) memad_d = cmd_ad;
    if (accept && cmd_we) begin
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
      memdi_d = {^cmd_di, cmd_di};
`else
      memdi_d = cmd_di;
`endif
    end
  end

  // Credits: a read holds one from acceptance until its response is popped
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (rd_acc && !pop)      out_cnt_d = out_cnt_q + ONE_C;
    else if (!rd_acc && pop) out_cnt_d = out_cnt_q - ONE_C;
  end

  // Shifting response FIFO; entry 0 is the registered head
  always_comb begin
    fdat_d = fdat_q;
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
    ferr_d = ferr_q;
`endif
    fcnt_d = fcnt_q;
    wr_idx = pop ? (fcnt_q - ONE_C) : fcnt_q;
    if (pop) begin
      for (int i = 0; i < G_RSP_DEPTH - 1; i++) begin
        fdat_d[i] = fdat_q[i+1];
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
        ferr_d[i] = ferr_q[i+1];
`endif
      end
      fdat_d[G_RSP_DEPTH-1] = '0;
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
      ferr_d[G_RSP_DEPTH-1] = 1'b0;
`endif
    end
    if (push) begin
      for (int i = 0; i < G_RSP_DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          fdat_d[i] = memdo_a[G_WIDTH-1:0];
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
          ferr_d[i] = ^memdo_a;
`endif
        end
      end
    end
    if (push && !pop)      fcnt_d = fcnt_q + ONE_C;
    else if (!push && pop) fcnt_d = fcnt_q - ONE_C;
  end

  // State registers; reset flushes credits, read pipeline and FIFO
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      state_q   <= ST_CLR;
      out_cnt_q <= '0;
      fcnt_q    <= '0;
      memad_q   <= '0;
      memdi_q   <= '0;
      memwe_q   <= 1'b0;
      memre_q   <= 1'b0;
      re_d1_q   <= 1'b0;
      re_d2_q   <= 1'b0;
      fdat_q    <= '{default: '0};
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
      ferr_q    <= '{default: 1'b0};
`endif
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
      fcnt_q    <= fcnt_d;
      memad_q   <= memad_d;
      memdi_q   <= memdi_d;
      memwe_q   <= memwe_d;
      memre_q   <= memre_d;
      re_d1_q   <= re_d1_d;
      re_d2_q   <= re_d2_d;
      fdat_q    <= fdat_d;
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
      ferr_q    <= ferr_d;
`endif
    end
  end

  assign memad_a = memad_q;
  assign memdi_a = memdi_q;
  assign memwe_a = memwe_q;
  assign memre_a = memre_q;
  assign rsp_do  = fdat_q[0];
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  assign rsp_err = ferr_q[0];
`else
  assign rsp_err = 1'b0;
`endif

  // The credit rule makes a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk_a) disable iff (!rst_n)
    !(push && !pop && (fcnt_q == DEPTH_C)));
  a_one_enable: assert property (@(posedge clk_a) !(memwe_q && memre_q));

endmodule

// File: tb/tb_rtlmem_2rw2x_ctrl.sv
// Directed bench for rtlmem_2rw2x_ctrl with a behavioural 2-cycle write-first RAM.
module tb_rtlmem_2rw2x_ctrl;
  localparam int G_ADDR      = 10;
  localparam int G_WIDTH     = 16;
  localparam int G_RSP_DEPTH = 4;
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DW = G_WIDTH + P;

  logic               clk_a = 1'b0;
  logic               rst_n = 1'b0;
  logic               init_req = 1'b0;
  logic               init_done;
  logic               cmd_vld = 1'b0;
  logic               cmd_rdy;
  logic               cmd_we = 1'b0;
  logic [G_ADDR-1:0]  cmd_ad = '0;
  logic [G_WIDTH-1:0] cmd_di = '0;
  logic               rsp_vld;
  logic               rsp_rdy = 1'b0;
  logic [G_WIDTH-1:0] rsp_do;
  logic               rsp_err;
  logic               clren;
  logic               clrrdy;
  logic [G_ADDR-1:0]  memad_a;
  logic               memwe_a;
  logic [DW-1:0]      memdi_a;
  logic               memre_a;
  logic [DW-1:0]      memdo_a;

  logic [DW-1:0]      mem [0:1023];
  logic [DW-1:0]      rd_s1, ram_do_q;
  logic               clr_auto = 1'b0;
  logic               man_rdy  = 1'b0;
  logic               auto_rdy = 1'b0;
  int                 clr_cnt  = 0;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  rtlmem_2rw2x_ctrl #(.G_ADDR(G_ADDR), .G_WIDTH(G_WIDTH), .G_RSP_DEPTH(G_RSP_DEPTH)) dut (
    .clk_a(clk_a), .rst_n(rst_n), .init_req(init_req), .init_done(init_done),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we), .cmd_ad(cmd_ad), .cmd_di(cmd_di),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_do(rsp_do), .rsp_err(rsp_err),
    .clren(clren), .clrrdy(clrrdy), .memad_a(memad_a), .memwe_a(memwe_a),
    .memdi_a(memdi_a), .memre_a(memre_a), .memdo_a(memdo_a));

  always #5 clk_a = ~clk_a;

  // RAM model: write-first, read data valid two cycles after the read enable
  always @(posedge clk_a) begin
    if (memwe_a) mem[memad_a] <= memdi_a;
    rd_s1    <= mem[memad_a];
    ram_do_q <= rd_s1;
    if (clren && clrrdy) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end
    if (!clren) begin
      clr_cnt  <= 0;
      auto_rdy <= 1'b0;
    end else begin
      clr_cnt <= clr_cnt + 1;
      if (clr_cnt == 3) auto_rdy <= 1'b1;
    end
  end

  assign clrrdy = clr_auto ? auto_rdy : man_rdy;

`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  logic flip = 1'b0;
  assign memdo_a = ram_do_q ^ {flip, {G_WIDTH{1'b0}}};
`else
  assign memdo_a = ram_do_q;
`endif

  task automatic nxt();
    @(posedge clk_a);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_a);
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      smp();
      if (rsp_vld) begin
        got = 1'b1;
        break;
      end
      nxt();
    end
  endtask

  task automatic wait_run(output bit got);
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      smp();
      if (init_done) begin
        got = 1'b1;
        break;
      end
      nxt();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) nxt();
    rst_n = 1'b1;
    smp();
    n_cmp++;
    if ({cmd_rdy, init_done, rsp_vld, rsp_err, memwe_a, memre_a, clren} !== 7'b0000001) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 0000001", {cmd_rdy, init_done, rsp_vld, rsp_err, memwe_a, memre_a, clren});
    end
    n_cmp++;
    if ({rsp_do, memad_a, memdi_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got do=%h ad=%h di=%h want 0", rsp_do, memad_a, memdi_a);
    end
    nxt();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) begin
      smp();
      n_cmp++;
      if ({clren, cmd_rdy, init_done} !== 3'b100) begin
        n_bad++;
        $display("FAIL clr_hold[%0d]: got %b want 100", i, {clren, cmd_rdy, init_done});
      end
      nxt();
    end
    man_rdy = 1'b1;
    smp();
    n_cmp++;
    if ({clren, cmd_rdy, init_done} !== 3'b100) begin
      n_bad++;
      $display("FAIL clr_rdy_cycle: got %b want 100", {clren, cmd_rdy, init_done});
    end
    nxt();
    man_rdy  = 1'b0;
    clr_auto = 1'b1;
    smp();
    n_cmp++;
    if ({clren, cmd_rdy, init_done} !== 3'b011) begin
      n_bad++;
      $display("FAIL clr_to_run: got %b want 011", {clren, cmd_rdy, init_done});
    end
    nxt();
  endtask

  task automatic test_raw();
    logic [DW-1:0] exp_di;
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
    exp_di = 17'h0A5A5;
`else
    exp_di = 16'hA5A5;
`endif
    rsp_rdy = 1'b1;
    cmd_vld = 1'b1; cmd_we = 1'b1; cmd_ad = 10'h005; cmd_di = 16'hA5A5;
    smp();
    n_cmp++;
    if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL raw_wr_rdy: got %b want 1", cmd_rdy); end
    nxt();
    cmd_we = 1'b0;
    smp();
    n_cmp++;
    if ({memwe_a, memre_a, memad_a, memdi_a} !== {2'b10, 10'h005, exp_di}) begin
      n_bad++;
      $display("FAIL raw_wr_issue: got we=%b re=%b ad=%h di=%h want 1 0 005 %h", memwe_a, memre_a, memad_a, memdi_a, exp_di);
    end
    nxt();
    cmd_vld = 1'b0;
    smp();
    n_cmp++;
    if ({memwe_a, memre_a, memad_a, rsp_vld} !== {2'b01, 10'h005, 1'b0}) begin
      n_bad++;
      $display("FAIL raw_rd_issue: got we=%b re=%b ad=%h vld=%b want 0 1 005 0", memwe_a, memre_a, memad_a, rsp_vld);
    end
    nxt();
    for (int c = 3; c <= 4; c++) begin
      smp();
      n_cmp++;
      if (rsp_vld !== 1'b0) begin n_bad++; $display("FAIL raw_early_vld c%0d: got %b want 0", c, rsp_vld); end
      nxt();
    end
    smp();
    n_cmp++;
    if ({rsp_vld, rsp_err, rsp_do} !== {2'b10, 16'hA5A5}) begin
      n_bad++;
      $display("FAIL raw_rsp: got vld=%b err=%b do=%h want 1 0 a5a5", rsp_vld, rsp_err, rsp_do);
    end
    nxt();
    smp();
    n_cmp++;
    if (rsp_vld !== 1'b0) begin n_bad++; $display("FAIL raw_pop: got %b want 0", rsp_vld); end
    nxt();
  endtask

  task automatic test_credits();
    logic [15:0] exp_d [4];
    int acc;
    exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rsp_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmd_vld = 1'b1; cmd_we = 1'b1; cmd_ad = 10'h010 + 10'(k); cmd_di = exp_d[k];
      smp();
      n_cmp++;
      if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_rdy[%0d]: got %b want 1", k, cmd_rdy); end
      nxt();
    end
    acc = 0;
    cmd_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_ad = 10'h010 + 10'(acc);
      smp();
      n_cmp++;
      if (cmd_rdy !== (i < 4)) begin n_bad++; $display("FAIL credit_rdy[%0d]: got %b want %b", i, cmd_rdy, (i < 4)); end
      if (cmd_rdy) acc++;
      nxt();
    end
    cmd_vld = 1'b0;
    n_cmp++;
    if (acc != 4) begin n_bad++; $display("FAIL credit_accepted: got %0d want 4", acc); end
    repeat (2) nxt();
    smp();
    n_cmp++;
    if ({rsp_vld, cmd_rdy, rsp_do} !== {2'b10, 16'h1111}) begin
      n_bad++;
      $display("FAIL stall_head: got vld=%b rdy=%b do=%h want 1 0 1111", rsp_vld, cmd_rdy, rsp_do);
    end
    nxt();
    smp();
    n_cmp++;
    if ({rsp_vld, rsp_do} !== {1'b1, 16'h1111}) begin
      n_bad++;
      $display("FAIL stall_hold: got vld=%b do=%h want 1 1111", rsp_vld, rsp_do);
    end
    nxt();
    rsp_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      smp();
      n_cmp++;
      if ({rsp_vld, rsp_do} !== {1'b1, exp_d[j]}) begin
        n_bad++;
        $display("FAIL order[%0d]: got vld=%b do=%h want 1 %h", j, rsp_vld, rsp_do, exp_d[j]);
      end
      nxt();
    end
    smp();
    n_cmp++;
    if ({rsp_vld, cmd_rdy} !== 2'b01) begin
      n_bad++;
      $display("FAIL credits_back: got vld=%b rdy=%b want 0 1", rsp_vld, cmd_rdy);
    end
    nxt();
  endtask

  task automatic test_reinit();
    bit got;
    rsp_rdy = 1'b1;
    cmd_vld = 1'b1; cmd_we = 1'b0; cmd_ad = 10'h010;
    smp();
    nxt();
    cmd_ad = 10'h011;
    smp();
    nxt();
    init_req = 1'b1; cmd_ad = 10'h012;
    smp();
    n_cmp++;
    if (cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL init_rdy_drop: got %b want 0", cmd_rdy); end
    nxt();
    init_req = 1'b0; cmd_vld = 1'b0;
    smp();
    n_cmp++;
    if ({clren, cmd_rdy, init_done, rsp_vld} !== 4'b0000) begin
      n_bad++;
      $display("FAIL drain_entry: got %b want 0000", {clren, cmd_rdy, init_done, rsp_vld});
    end
    nxt();
    smp();
    n_cmp++;
    if ({clren, rsp_vld, rsp_do} !== {2'b01, 16'h1111}) begin
      n_bad++;
      $display("FAIL drain_rsp0: got clren=%b vld=%b do=%h want 0 1 1111", clren, rsp_vld, rsp_do);
    end
    nxt();
    smp();
    n_cmp++;
    if ({clren, rsp_vld, rsp_do} !== {2'b01, 16'h2222}) begin
      n_bad++;
      $display("FAIL drain_rsp1: got clren=%b vld=%b do=%h want 0 1 2222", clren, rsp_vld, rsp_do);
    end
    nxt();
    smp();
    n_cmp++;
    if ({clren, rsp_vld} !== 2'b10) begin
      n_bad++;
      $display("FAIL drain_to_clr: got clren=%b vld=%b want 1 0", clren, rsp_vld);
    end
    nxt();
    wait_run(got);
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL reinit_timeout: got no init_done want init_done=1"); end
    nxt();
    cmd_vld = 1'b1; cmd_we = 1'b0; cmd_ad = 10'h010;
    smp();
    nxt();
    cmd_vld = 1'b0;
    wait_rsp(got);
    n_cmp++;
    if (!got || rsp_do !== 16'h0000) begin
      n_bad++;
      $display("FAIL cleared_read: got vld=%b do=%h want 1 0000", got, rsp_do);
    end
    nxt();
  endtask

  task automatic test_reset_inflight();
    bit got;
    bit seen;
    rsp_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_vld = 1'b1; cmd_we = 1'b0; cmd_ad = 10'h010 + 10'(k);
      smp();
      nxt();
    end
    cmd_vld = 1'b0;
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    smp();
    n_cmp++;
    if ({cmd_rdy, init_done, rsp_vld, rsp_err, memwe_a, memre_a, clren} !== 7'b0000001) begin
      n_bad++;
      $display("FAIL rst_mid_ctl: got %b want 0000001", {cmd_rdy, init_done, rsp_vld, rsp_err, memwe_a, memre_a, clren});
    end
    n_cmp++;
    if ({rsp_do, memad_a, memdi_a} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_data: got do=%h ad=%h di=%h want 0", rsp_do, memad_a, memdi_a);
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      nxt();
      smp();
      if (rsp_vld) seen = 1'b1;
    end
    nxt();
    wait_run(got);
    n_cmp++;
    if (seen || !got) begin
      n_bad++;
      $display("FAIL rst_discard: got stale_vld=%b run=%b want 0 1", seen, got);
    end
    n_cmp++;
    if (cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_credits: got rdy=%b want 1", cmd_rdy); end
    nxt();
  endtask

`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
  task automatic test_parity();
    bit got;
    rsp_rdy = 1'b1;
    cmd_vld = 1'b1; cmd_we = 1'b1; cmd_ad = 10'h020; cmd_di = 16'h0001;
    smp();
    nxt();
    cmd_vld = 1'b0;
    smp();
    n_cmp++;
    if (memdi_a !== 17'h10001) begin n_bad++; $display("FAIL par_wr: got %h want 10001", memdi_a); end
    nxt();
    for (int f = 1; f >= 0; f--) begin
      flip = f[0];
      cmd_vld = 1'b1; cmd_we = 1'b0; cmd_ad = 10'h020;
      smp();
      nxt();
      cmd_vld = 1'b0;
      wait_rsp(got);
      n_cmp++;
      if (!got || {rsp_err, rsp_do} !== {f[0], 16'h0001}) begin
        n_bad++;
        $display("FAIL par_rd flip=%0d: got vld=%b err=%b do=%h want 1 %0d 0001", f, got, rsp_err, rsp_do, f);
      end
      nxt();
    end
    flip = 1'b0;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish before 300000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_raw();
    test_credits();
    test_reinit();
    test_reset_inflight();
`ifdef RTLMEM_2RW2X_CTRL_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtlmem_2rw2x_ctrl.md
Name: rtlmem_2rw2x_ctrl

Overview:
- Request controller that sits directly upstream of port A of the 2-port, 2-cycle-read shared RAM wrapper.
- Accepts read/write commands over a valid/ready interface and sequences the RAM clear after reset or on request.
- Tracks the fixed 2-cycle read latency and returns read data through a credit-protected response FIFO with backpressure.

Parameters:
G_ADDR, 10, address width (matches RAM G_ADDR_A)
G_WIDTH, 16, user data width
G_RSP_DEPTH, 4, response FIFO depth and max outstanding reads; legal range 2..16

Ports:
clk_a  in  1  clock, same clock as RAM port A
rst_n  in  1  synchronous, active-low reset
init_req  in  1  pulse: request re-clear of RAM contents
init_done  out  1  high when state is RUN
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready
cmd_we  in  1  1 = write, 0 = read
cmd_ad  in  G_ADDR  command address
cmd_di  in  G_WIDTH  write data
rsp_vld  out  1  read response valid
rsp_rdy  in  1  read response ready
rsp_do  out  G_WIDTH  read data
rsp_err  out  1  parity error flag, qualified by rsp_vld
clren  out  1  RAM clear enable
clrrdy  in  1  RAM clear complete
memad_a  out  G_ADDR  RAM address
memwe_a  out  1  RAM write enable
memdi_a  out  G_WIDTH+P  RAM write data; P=1 with parity option, else 0
memre_a  out  1  RAM read enable
memdo_a  in  G_WIDTH+P  RAM read data, valid 2 cycles after memre_a

Behaviour:
- Reset (rst_n=0 at a clk_a edge):
  - State goes to CLR.
  - All outputs 0: cmd_rdy, init_done, rsp_vld, rsp_do, rsp_err, memwe_a, memre_a, memad_a, memdi_a.
  - Exception: clren=1 in the cycle after reset release (CLR state).
  - Credit counter, read pipeline and response FIFO are flushed.
  - Reset mid-operation discards in-flight reads; no response is ever produced for them.
- States:
  - CLR: clren=1, cmd_rdy=0. Moves to RUN on the cycle clrrdy=1 is sampled.
  - RUN: init_done=1. If init_req=1, moves to DRAIN; cmd_rdy=0 in that same cycle.
  - DRAIN: cmd_rdy=0. Moves to CLR when the 3-stage read pipeline is empty. Response FIFO contents are kept and continue to drain.
- init_req is ignored in CLR and DRAIN.
- Credit rule:
  - out_cnt = reads in pipeline + FIFO occupancy, range 0..G_RSP_DEPTH.
  - cmd_rdy = (state==RUN) && (out_cnt < G_RSP_DEPTH).
  - cmd_rdy never depends on cmd_vld or cmd_we.
  - Read accept: out_cnt+1. rsp pop: out_cnt-1. Both in the same cycle: out_cnt unchanged.
- Issue timing:
  - Command accepted in cycle 0 (cmd_vld && cmd_rdy).
  - memad_a/memwe_a/memdi_a/memre_a are registered and driven in cycle 1.
  - Enables last exactly 1 cycle; memwe_a and memre_a are never both high.
- Read return:
  - memdo_a is sampled in cycle 3 and pushed to the FIFO.
  - rsp_vld=1 earliest in cycle 4; rsp_do/rsp_err come from the FIFO head.
- FIFO:
  - First-word registered, in-order.
  - Cannot overflow because of the credit rule; any overflow is a design bug (assert in sim).
  - Pop on rsp_vld && rsp_rdy.
  - rsp_do/rsp_err hold stable while rsp_vld=1 and rsp_rdy=0.
- Back-to-back: 1 command per cycle sustained while credits remain.
- Ordering:
  - Read-after-write to the same address in consecutive cycles returns the new data (RAM is write-first, single port, in order).
  - Responses return in command order.

Optional Feature:
Macro: RTLMEM_2RW2X_CTRL_PARITY_EN
- Defined:
  - P=1; memdi_a[G_WIDTH] = XOR of cmd_di (even parity).
  - On read, rsp_err = XOR of all G_WIDTH+1 bits of memdo_a, stored in the FIFO alongside the data.
  - Cleared RAM (all zero) checks clean.
- Undefined:
  - P=0; memdi_a/memdo_a are G_WIDTH wide.
  - rsp_err is tied 0 and no parity logic is present.

Test Plan:
1. Reset, hold clrrdy=0 for 10 cycles, then 1 -> clren=1 and cmd_rdy=0 throughout; init_done=1 in the cycle after clrrdy is sampled.
2. Write ad=0x005 di=0xA5A5, next cycle read ad=0x005, rsp_rdy=1 -> memwe_a in cycle 1, memre_a in cycle 2, rsp_vld in cycle 5 with rsp_do=0xA5A5.
3. rsp_rdy=0, issue 6 reads with G_RSP_DEPTH=4 -> exactly 4 accepted, cmd_rdy=0 after the 4th. Raise rsp_rdy -> 4 responses in order, then cmd_rdy=1.
4. init_req while 2 reads are in flight -> cmd_rdy=0 immediately, both responses still delivered, clren=1 after the pipeline empties; a read after init_done returns 0x0000.
5. rst_n=0 for 1 cycle with 3 reads outstanding -> no rsp_vld ever for them; all outputs 0 except clren=1 after reset release.
6. With RTLMEM_2RW2X_CTRL_PARITY_EN: write 0x0001, force memdo_a bit 16 flipped on readback -> rsp_err=1 with rsp_do=0x0001; unflipped -> rsp_err=0.
